// File: rtl/pulse_queue.sv
// pulse_queue: counts single-cycle event pulses and hands them out one at a time over a 4-phase REQ/ACK handshake.
// Optional drop counter output is enabled by defining PULSE_QUEUE_DROP_CNT_EN.
module pulse_queue #(
    parameter int CNT_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 pulse_in,
    input  logic                 ack,
    input  logic                 ovf_clr,
    output logic                 req,
    output logic [CNT_WIDTH-1:0] pend,
    output logic                 empty,
    output logic                 full,
    output logic                 ovf
`ifdef PULSE_QUEUE_DROP_CNT_EN
    ,
    output logic [7:0]           drop_cnt
`endif
);
    typedef enum logic [1:0] {IDLE, REQ_HI, REQ_LO} state_t;
    state_t state, state_nx;
    logic dec, drop;
    logic [CNT_WIDTH-1:0] pend_nx;
    assign empty = pend == '0;
    assign full  = &pend;
    always_comb begin
        state_nx = (state == IDLE   && !empty) ? REQ_HI :
                   (state == REQ_HI &&  ack)   ? REQ_LO :
                   (state == REQ_LO && !ack)   ? IDLE   : state;
        dec      = state == REQ_HI && ack;
        // a pulse coinciding with a decrement cancels out, even when full
        drop     = pulse_in && full && !dec;
        pend_nx  = (pulse_in && !dec && !full) ? pend + 1'b1 :
                   (dec && !pulse_in)          ? pend - 1'b1 : pend;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            req   <= 1'b0;
            pend  <= '0;
            ovf   <= 1'b0;
        end else begin
            state <= state_nx;
            req   <= state_nx == REQ_HI;
            pend  <= pend_nx;
            ovf   <= drop | (ovf & ~ovf_clr);
        end
    end
`ifdef PULSE_QUEUE_DROP_CNT_EN
    always_ff @(posedge clk) begin
        if (rst)
            drop_cnt <= 8'd0;
        else if (drop)
            drop_cnt <= drop_cnt + {7'd0, drop_cnt != 8'hFF};
        else if (ovf_clr)
            drop_cnt <= 8'd0;
    end
`endif
endmodule
